// File: rtl/write_controller.sv
// write_controller: assembles UART write packets into a one-cycle register-file write strobe.
// Optional acknowledge beat to the transmitter when WRITE_CONTROLLER_ACK_EN is defined.
module write_controller #(
    parameter logic [7:0] WRITE_DEST = 8'h01,
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] ACK_SOURCE = 8'h01
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic [7:0]              ipRxSource,
    input  logic [7:0]              ipRxDestination,
    input  logic [7:0]              ipRxLength,
    input  logic [7:0]              ipRxData,
    input  logic                    ipRxSoP,
    input  logic                    ipRxEoP,
    input  logic                    ipRxValid,
    output logic [7:0]              opWrAddress,
    output logic [8*DATA_BYTES-1:0] opWrData,
    output logic                    opWrEnable
`ifdef WRITE_CONTROLLER_ACK_EN
    ,
    input  logic                    ipTxReady,
    output logic [7:0]              opTxSource,
    output logic [7:0]              opTxDestination,
    output logic [7:0]              opTxLength,
    output logic [7:0]              opTxData,
    output logic                    opTxSoP,
    output logic                    opTxEoP,
    output logic                    opTxValid
`endif
);
    localparam int CW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
    typedef enum logic [2:0] {
        IDLE,
        DATA,
        DROP,
`ifdef WRITE_CONTROLLER_ACK_EN
        ACK,
`endif
        COMMIT
    } state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [7:0]              addr_cap_q, addr_cap_d, wr_addr_q, wr_addr_d;
    logic [8*DATA_BYTES-1:0] buf_q, buf_d, wr_data_q, wr_data_d;
    logic                    start, resync, last, unused_src;
    assign unused_src = ^{ipRxSource, ACK_SOURCE};
    assign start  = ipRxValid && ipRxSoP && ipRxDestination == WRITE_DEST
                    && ipRxLength == 8'(DATA_BYTES + 1);
    assign resync = ipRxValid && ipRxSoP && (state_q == DATA || state_q == DROP);
    assign last   = cnt_q == CW'(DATA_BYTES - 1);
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_cap_d = addr_cap_q;
        buf_d      = buf_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        // A SoP mid-packet is treated exactly as if it arrived in IDLE
        if (state_q == IDLE || resync) begin
            state_d = start ? DATA : IDLE;
            if (start) begin
                addr_cap_d = ipRxData;
                cnt_d      = '0;
            end
        end else if (state_q == DATA && ipRxValid) begin
            buf_d[8*cnt_q +: 8] = ipRxData;
            if (last) begin
                state_d = ipRxEoP ? COMMIT : DROP;
                if (ipRxEoP) begin
                    wr_addr_d = addr_cap_q;
                    wr_data_d = buf_d;
                end
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ipRxEoP ? IDLE : DATA;
            end
        end else if (state_q == DROP && ipRxValid && ipRxEoP) begin
            state_d = IDLE;
        end else if (state_q == COMMIT) begin
`ifdef WRITE_CONTROLLER_ACK_EN
            state_d = ACK;
        end else if (state_q == ACK && ipTxReady) begin
`endif
            state_d = IDLE;
        end
    end
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_cap_q <= '0;
            buf_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_cap_q <= addr_cap_d;
            buf_q      <= buf_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end
    assign opWrAddress = wr_addr_q;
    assign opWrData    = wr_data_q;
    assign opWrEnable  = state_q == COMMIT;
`ifdef WRITE_CONTROLLER_ACK_EN
    logic ack;
    assign ack             = state_q == ACK;
    assign opTxValid       = ack;
    assign opTxSoP         = ack;
    assign opTxEoP         = ack;
    assign opTxSource      = ack ? ACK_SOURCE : '0;
    assign opTxDestination = ack ? WRITE_DEST : '0;
    assign opTxLength      = ack ? 8'd1 : '0;
    assign opTxData        = ack ? wr_addr_q : '0;
`endif
endmodule

// File: tb/tb_write_controller.sv
// tb_write_controller: directed packets with a write scoreboard checked by an independent monitor.
module tb_write_controller;
    logic        ipClk = 0, ipReset = 1;
    logic [7:0]  ipRxSource = 0, ipRxDestination = 0, ipRxLength = 0, ipRxData = 0;
    logic        ipRxSoP = 0, ipRxEoP = 0, ipRxValid = 0;
    logic [7:0]  opWrAddress;
    logic [31:0] opWrData;
    logic        opWrEnable;
    int          vectors = 0, miss = 0;
    logic [39:0] exp_q[$];
    logic        prev_en = 0;
`ifdef WRITE_CONTROLLER_ACK_EN
    localparam int GAP = 2;
    logic        ipTxReady = 1;
    logic [7:0]  opTxSource, opTxDestination, opTxLength, opTxData;
    logic        opTxSoP, opTxEoP, opTxValid;
`else
    localparam int GAP = 1;
`endif

    write_controller dut (
        .ipClk(ipClk), .ipReset(ipReset),
        .ipRxSource(ipRxSource), .ipRxDestination(ipRxDestination),
        .ipRxLength(ipRxLength), .ipRxData(ipRxData),
        .ipRxSoP(ipRxSoP), .ipRxEoP(ipRxEoP), .ipRxValid(ipRxValid),
        .opWrAddress(opWrAddress), .opWrData(opWrData), .opWrEnable(opWrEnable)
`ifdef WRITE_CONTROLLER_ACK_EN
        , .ipTxReady(ipTxReady),
        .opTxSource(opTxSource), .opTxDestination(opTxDestination),
        .opTxLength(opTxLength), .opTxData(opTxData),
        .opTxSoP(opTxSoP), .opTxEoP(opTxEoP), .opTxValid(opTxValid)
`endif
    );

    always #5 ipClk = ~ipClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [7:0] dest,
                        input logic [7:0] len, input logic [7:0] d);
        ipRxValid = 1; ipRxSoP = sop; ipRxEoP = eop;
        ipRxDestination = dest; ipRxLength = len; ipRxData = d; ipRxSource = 8'h3C;
        @(posedge ipClk); #1;
        ipRxValid = 0; ipRxSoP = 0; ipRxEoP = 0;
    endtask

    task automatic pkt(input logic [7:0] dest, input logic [7:0] len, input logic [7:0] addr,
                       input logic [31:0] d, input int nb, input int eop_at);
        beat(1, 0, dest, len, addr);
        for (int i = 0; i < nb; i++) beat(0, i == eop_at, 8'h00, 8'h00, d[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ipClk);
        #1;
    endtask

    task automatic hold(input string name, input logic [7:0] a, input logic [31:0] d);
        chk({name, "_addr"}, opWrAddress, a);
        chk({name, "_data"}, opWrData, d);
    endtask

    // Monitor: every strobe must match the oldest expected write
    initial forever begin
        @(negedge ipClk);
        if (opWrEnable) begin
            chk("strobe_width", prev_en, 0);
            if (exp_q.size() == 0) chk("unexpected_write", opWrEnable, 0);
            else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", opWrAddress, e[39:32]);
                chk("wr_data", opWrData, e[31:0]);
            end
        end
        prev_en = opWrEnable;
    end

    initial begin
        idle(2);
        chk("rst_en", opWrEnable, 0);
        hold("rst", 8'h00, 32'h0);
        ipReset = 0;
        idle(1);
        exp_q.push_back({8'h22, 32'hDEADBEEF});
        pkt(8'h01, 8'd5, 8'h22, 32'hDEADBEEF, 4, 3);
        idle(GAP);
        pkt(8'h00, 8'd5, 8'h22, 32'h01020304, 4, 3);
        idle(GAP);
        pkt(8'h01, 8'd3, 8'h23, 32'h01020304, 4, 3);
        idle(GAP);
        hold("bad_hdr", 8'h22, 32'hDEADBEEF);
        pkt(8'h01, 8'd5, 8'h33, 32'h00332211, 3, 2);
        idle(GAP);
        hold("early_eop", 8'h22, 32'hDEADBEEF);
        exp_q.push_back({8'h05, 32'h12345678});
        pkt(8'h01, 8'd5, 8'h05, 32'h12345678, 4, 3);
        idle(GAP);
        pkt(8'h01, 8'd5, 8'h44, 32'h0000BBAA, 2, 99);
        exp_q.push_back({8'h07, 32'hCAFEF00D});
        pkt(8'h01, 8'd5, 8'h07, 32'hCAFEF00D, 4, 3);
        idle(GAP);
        pkt(8'h01, 8'd5, 8'h55, 32'h00000201, 2, 99);
        ipReset = 1;
        #1;
        chk("midrst_en", opWrEnable, 0);
        hold("midrst", 8'h00, 32'h0);
        @(posedge ipClk); #1;
        ipReset = 0;
        idle(1);
        exp_q.push_back({8'h66, 32'hA5A55A5A});
        pkt(8'h01, 8'd5, 8'h66, 32'hA5A55A5A, 4, 3);
        idle(GAP);
        pkt(8'h01, 8'd5, 8'h77, 32'h11111111, 4, 99);
        beat(0, 1, 8'h00, 8'h00, 8'h99);
        hold("drop", 8'h66, 32'hA5A55A5A);
        pkt(8'h01, 8'd5, 8'h78, 32'h22222222, 4, 99);
        exp_q.push_back({8'h88, 32'h89ABCDEF});
        pkt(8'h01, 8'd5, 8'h88, 32'h89ABCDEF, 4, 3);
        idle(GAP);
        exp_q.push_back({8'h10, 32'h00000001});
        exp_q.push_back({8'hFF, 32'hFFFFFFFF});
        pkt(8'h01, 8'd5, 8'h10, 32'h00000001, 4, 3);
        idle(GAP);
        pkt(8'h01, 8'd5, 8'hFF, 32'hFFFFFFFF, 4, 3);
        idle(GAP);
`ifdef WRITE_CONTROLLER_ACK_EN
        exp_q.push_back({8'h22, 32'hDEADBEEF});
        ipTxReady = 0;
        pkt(8'h01, 8'd5, 8'h22, 32'hDEADBEEF, 4, 3);
        @(posedge ipClk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ipClk);
            chk("ack_valid", opTxValid, 1);
            chk("ack_data", opTxData, 8'h22);
            chk("ack_sop_eop", {opTxSoP, opTxEoP}, 2'b11);
        end
        chk("ack_hdr", {opTxSource, opTxDestination, opTxLength}, 24'h010101);
        ipTxReady = 1;
        @(posedge ipClk); #1;
        chk("ack_drop", opTxValid, 0);
        idle(1);
`endif
        idle(2);
        chk("pending_writes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
